keypad_emulator: RTL and testbench

Responder end of the 4x4 matrix-keypad scan interface. It watches the scanner's column drive and returns row levels as if a physical key were pressed, including contact bounce on press and release. It is used for on-board self-test and loopback benches, so the keyboard decoder can be exercised without a physical keypad. A press request carries a key index; the block plays one complete press/release sequence and pulses done.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_phase_timer.sv | 45 ++++
 rtl/keypad_emulator.sv | 123 ++++++++++++
 tb/tb_keypad_emulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad emulator and the keyboard decoder.
// Contents:
//   kp_state_e  - press-sequence FSM state
//   ROW_IDLE    - row bus level with no key closed (active-low rows)
//   KEY_*       - bit positions of the row/column fields inside a key index
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } kp_state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  localparam int KEY_ROW_HI = 3;
  localparam int KEY_ROW_LO = 2;
  localparam int KEY_COL_HI = 1;
  localparam int KEY_COL_LO = 0;

endpackage

// File: rtl/keypad_phase_timer.sv
// Phase timer shared by every phase of the press sequence.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - restart the phase (counters to 0) at this edge
//   length      - length of the current phase in cycles (>= 1)
//   period      - cycles per bounce slot (>= 1)
//   last        - current cycle is the final cycle of the phase
//   slot_odd    - current bounce slot index is odd
module keypad_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] length,
  input  logic [CNT_W-1:0] period,
  output logic             last,
  output logic             slot_odd
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] scnt;

  assign last = (cnt == length - CNT_W'(1));

  // The phase counter parks on its final value until the FSM reloads it, so it
  // never wraps on its own; the slot counter wraps every period and flips the
  // slot parity.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt      <= '0;
      scnt     <= '0;
      slot_odd <= 1'b0;
    end else begin
      if (!last) cnt <= cnt + CNT_W'(1);
      if (scnt == period - CNT_W'(1)) begin
        scnt     <= '0;
        slot_odd <= ~slot_odd;
      end else begin
        scnt <= scnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder. Plays one press/release of a requested key,
// with contact bounce on both edges, by pulling the key's row low whenever its
// column is driven low while the emulated contact is closed.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   col        - column drive from scanner, active-low
//   row        - row return to scanner, active-low, idle 4'b1111
//   key        - key index {row[1:0], col[1:0]}
//   press_req  - request one press (taken only while ready)
//   ready/busy - idle / sequence in progress
//   done       - one-cycle pulse on the last cycle of the sequence
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_PERIOD  = 2,
  parameter int BOUNCE_TOGGLES = 3,
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic [3:0] key,
  input  logic       press_req,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam longint BLEN = 64'(BOUNCE_TOGGLES) * 64'(BOUNCE_PERIOD);
  localparam longint CMAX = 64'(1) << CNT_W;
  localparam bit     NO_BOUNCE = (BOUNCE_TOGGLES == 0);

  localparam logic [CNT_W-1:0] BLEN_W = CNT_W'(BLEN);
  localparam logic [CNT_W-1:0] HOLD_W = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_W  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] PER_W  = CNT_W'(BOUNCE_PERIOD);

  generate
    if (BOUNCE_PERIOD < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_TOGGLES < 0 ||
        BLEN > CMAX || 64'(HOLD_CYCLES) > CMAX || 64'(GAP_CYCLES) > CMAX ||
        64'(BOUNCE_PERIOD) > CMAX) begin : g_bad_params
      $error("keypad_emulator: phase length out of range for CNT_W");
    end
  endgenerate

  kp_state_e        state;
  logic [3:0]       key_q;
  logic [CNT_W-1:0] len;
  logic             last;
  logic             slot_odd;
  logic             accept;
  logic             load;
  logic             contact;

  assign busy   = (state != IDLE);
  assign ready  = ~busy;
  assign accept = ready & press_req;
  // Restart the timer on acceptance and on every phase boundary.
  assign load   = accept | (busy & last);
  assign done   = (state == GAP) & last;

  // Length of the phase currently running; IDLE uses 1 so the timer rests at 0.
  always_comb begin
    len = CNT_W'(1);
    case (state)
      BOUNCE_IN, BOUNCE_OUT: len = BLEN_W;
      HOLD:                  len = HOLD_W;
      GAP:                   len = GAP_W;
      default:               len = CNT_W'(1);
    endcase
  end

  keypad_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .length   (len),
    .period   (PER_W),
    .last     (last),
    .slot_odd (slot_odd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          key_q <= key;
          state <= NO_BOUNCE ? HOLD : BOUNCE_IN;
        end
        BOUNCE_IN:  if (last) state <= HOLD;
        HOLD:       if (last) state <= NO_BOUNCE ? GAP : BOUNCE_OUT;
        BOUNCE_OUT: if (last) state <= GAP;
        GAP:        if (last) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Bounce-in closes on even slots, bounce-out closes on odd slots.
  always_comb begin
    contact = 1'b0;
    case (state)
      BOUNCE_IN:  contact = ~slot_odd;
      HOLD:       contact = 1'b1;
      BOUNCE_OUT: contact = slot_odd;
      default:    contact = 1'b0;
    endcase
  end

  // Combinational from col so a scan step shows up on row in the same cycle.
  always_comb begin
    row = ROW_IDLE;
    if (contact && !col[key_q[KEY_COL_HI:KEY_COL_LO]])
      row[key_q[KEY_ROW_HI:KEY_ROW_LO]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int BP = 2;
  localparam int HC = 10;
  localparam int GC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col = 4'hF;
  logic [3:0] key = 4'h0;
  logic       press_req = 1'b0;

  logic [3:0] row0, row1;
  logic       ready0, busy0, done0, ready1, busy1, done1;

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_PERIOD(BP), .BOUNCE_TOGGLES(3), .HOLD_CYCLES(HC),
                    .GAP_CYCLES(GC), .CNT_W(24)) d0 (
    .clk(clk), .reset(reset), .col(col), .row(row0), .key(key),
    .press_req(press_req), .ready(ready0), .busy(busy0), .done(done0));

  keypad_emulator #(.BOUNCE_PERIOD(BP), .BOUNCE_TOGGLES(0), .HOLD_CYCLES(HC),
                    .GAP_CYCLES(GC), .CNT_W(24)) d1 (
    .clk(clk), .reset(reset), .col(col), .row(row1), .key(key),
    .press_req(press_req), .ready(ready1), .busy(busy1), .done(done1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
  endtask

  // ---- behavioural model: position k (1..total) inside a press sequence ----
  int bt[2] = '{3, 0};
  bit m_busy[2] = '{1'b0, 1'b0};
  int m_k[2] = '{0, 0};
  logic [3:0] m_key[2] = '{4'h0, 4'h0};

  function automatic int total_len(input int t_bt);
    return 2 * t_bt * BP + HC + GC;
  endfunction

  function automatic bit closed_at(input int k, input int t_bt);
    int b = t_bt * BP;
    int j = k - 1;
    if (j < 0) return 1'b0;
    if (j < b) return ((j / BP) % 2) == 0;
    j -= b;
    if (j < HC) return 1'b1;
    j -= HC;
    if (j < b) return ((j / BP) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(input bit cl, input logic [3:0] kk, input logic [3:0] c);
    logic [3:0] r = 4'hF;
    if (cl && c[kk[1:0]] == 1'b0) r[kk[3:2]] = 1'b0;
    return r;
  endfunction

  task automatic model_check(input int i, input logic [3:0] r, input logic rd,
                             input logic b, input logic d);
    bit cl = m_busy[i] && closed_at(m_k[i], bt[i]);
    chk($sformatf("m%0d.row", i), 32'(r), 32'(exp_row(cl, m_key[i], col)));
    chk($sformatf("m%0d.ready", i), 32'(rd), 32'(!m_busy[i]));
    chk($sformatf("m%0d.busy", i), 32'(b), 32'(m_busy[i]));
    chk($sformatf("m%0d.done", i), 32'(d), 32'(m_busy[i] && m_k[i] == total_len(bt[i])));
    if (reset) m_busy[i] = 1'b0;
    else if (m_busy[i]) begin
      if (m_k[i] == total_len(bt[i])) m_busy[i] = 1'b0;
      else m_k[i]++;
    end else if (press_req) begin
      m_busy[i] = 1'b1;
      m_k[i] = 1;
      m_key[i] = key;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_check(0, row0, ready0, busy0, done0);
      model_check(1, row1, ready1, busy1, done1);
    end
  end

  // ---- directed stimulus with literal expectations ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] closed_map;
    logic [3:0] one;
    closed_map = 32'h0019_FFE6;  // cycles 1-2, 5-6, 7-16, 19-20
    one = 4'b0001;

    // 1: reset and idle with scanning columns
    cyc();
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      col = ~(one << (i % 4));
      key = 4'(i * 5);
      if (i == 4) reset = 1'b0;
      @(negedge clk);
      chk("t1.row0", 32'(row0), 32'hF);
      chk("t1.row1", 32'(row1), 32'hF);
      chk("t1.ready", 32'(ready0), 32'd1);
      chk("t1.busy", 32'(busy0), 32'd0);
      chk("t1.done", 32'(done0), 32'd0);
      cyc();
    end

    // 2: default press of key row1/col2 with its column selected
    key = 4'b0110; col = 4'b1011; press_req = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      chk($sformatf("t2.row@%0d", k), 32'(row0), closed_map[k] ? 32'hD : 32'hF);
      chk($sformatf("t2.done@%0d", k), 32'(done0), 32'(k == 26));
      chk($sformatf("t2.ready@%0d", k), 32'(ready0), 32'(k == 0 || k >= 27));
      cyc();
      press_req = 1'b0;
    end

    // 3: same press, other column scanned: row stays idle, timing unchanged
    key = 4'b0110; col = 4'b1110; press_req = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      chk($sformatf("t3.row@%0d", k), 32'(row0), 32'hF);
      chk($sformatf("t3.done@%0d", k), 32'(done0), 32'(k == 26));
      chk($sformatf("t3.busy@%0d", k), 32'(busy0), 32'(k >= 1 && k <= 26));
      cyc();
      press_req = 1'b0;
    end

    // 4: clean edges instance, key 15
    key = 4'b1111; col = 4'b0111; press_req = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      chk($sformatf("t4.row@%0d", k), 32'(row1), (k >= 1 && k <= 10) ? 32'h7 : 32'hF);
      chk($sformatf("t4.done@%0d", k), 32'(done1), 32'(k == 14));
      cyc();
      press_req = 1'b0;
    end

    // 5: request held high, key wiggled mid-sequence
    key = 4'b0110; col = 4'b1011; press_req = 1'b1;
    for (int k = 0; k <= 56; k++) begin
      @(negedge clk);
      chk($sformatf("t5.ready@%0d", k), 32'(ready0), 32'(k == 0 || k == 27 || k >= 54));
      chk($sformatf("t5.done@%0d", k), 32'(done0), 32'(k == 26 || k == 53));
      if (k == 5 || k == 20) chk($sformatf("t5.row@%0d", k), 32'(row0), 32'hD);
      cyc();
      if (k == 4) key = 4'b0000;
      if (k == 5) key = 4'b0110;
      if (k == 53) press_req = 1'b0;
    end
    for (int k = 0; k < 30; k++) cyc();  // let the clean-edge instance drain

    // 6: reset mid-press, then a normal press
    key = 4'b0110; col = 4'b1011; press_req = 1'b1;
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k == 12) chk("t6.row@12", 32'(row0), 32'hD);
      if (k == 13) begin
        chk("t6.row@13", 32'(row0), 32'hF);
        chk("t6.busy@13", 32'(busy0), 32'd0);
        chk("t6.ready@13", 32'(ready0), 32'd1);
      end
      if (k == 15) chk("t6.row@15", 32'(row0), 32'hD);
      if (k >= 13) chk($sformatf("t6.done@%0d", k), 32'(done0), 32'(k == 40));
      cyc();
      if (k == 0) press_req = 1'b0;
      if (k == 11) reset = 1'b1;
      if (k == 12) reset = 1'b0;
      if (k == 13) press_req = 1'b1;
      if (k == 14) press_req = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    total++;
    $display("FAIL timeout actual=running expected=finished");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
